keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
//
// PURPOSE
//   Scan driver for the 4x4 Pmod keypad on JA. Drives the column lines one at a
//   time and samples the row lines. Debounces across whole scans, then reports
//   the key code, a held-level detect flag and a one-cycle press pulse.
//   This is the producer the game FSM consumes on its keypad inputs.
//
// PARAMETERS
//   SETTLE_CYCLES   100_000  clk cycles each column is driven before rows are sampled (>=2)
//   DEBOUNCE_SCANS  3        consecutive full scans needed to accept a press or a release (>=1)
//
// PORTS
//   clk           in   1  system clock
//   rst_n         in   1  asynchronous, active-low reset
//   row           in   4  keypad rows (JA[7:4]), pulled up; low = key in driven column
//   col           out  4  keypad columns (JA[3:0]); exactly one bit low, others high
//   key           out  4  accepted key code; holds last value after release
//   key_detected  out  1  high while a debounced key is held
//   key_pulse     out  1  one-cycle pulse on the cycle key_detected rises
//
// BEHAVIOUR
//   - Reset values: col=4'b1110, key=0, key_detected=0, key_pulse=0; all counters,
//     the candidate code and the scan index cleared.
//   - row passes through a 2-FF synchronizer before any use.
//   - Column phase: col[i] is driven low for SETTLE_CYCLES cycles, i=0..3 in order.
//     Synced rows are sampled on the last cycle of the phase, then i advances (3 wraps to 0).
//     One scan is 4*SETTLE_CYCLES cycles.
//   - Key map, indexed [row][col]:
//     r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
//   - Within a scan, the first low row in scan order wins (col0 first, then row0 first).
//     Additional simultaneous keys are ignored.
//   - Each scan end (col3 sample) gives scan_found and scan_code.
//   - Idle (key_detected=0):
//     - found, code==candidate: press count +1.
//     - found, code differs: candidate<=code, count<=1.
//     - not found: count<=0.
//     - When count reaches DEBOUNCE_SCANS, in one cycle: key<=candidate,
//       key_detected<=1, key_pulse<=1. key_pulse drops next cycle.
//   - Held (key_detected=1):
//     - not found: release count +1.
//     - found (any code): release count<=0.
//     - At DEBOUNCE_SCANS, key_detected<=0, key unchanged, press count<=0.
//     - A change of held key without a full release gives no new pulse and no key update.
//   - Latency: a stable press is accepted at the end of scan DEBOUNCE_SCANS (or +1 if the
//     press lands mid-scan), plus 2 cycles of sync. Release timing is symmetric.
//   - Reset mid-scan or mid-press aborts everything to the reset values.
//     A key still held afterwards is re-debounced and produces a fresh key_pulse.
//   - Counter width: $clog2(SETTLE_CYCLES). The debounce counters saturate and never wrap.
//
// STRUCTURE
//   - Shared package: key code localparams (KEY_0..KEY_F), the map function
//     row/col -> code, and the column-phase index type.
//   - One sub-module, key_debouncer: takes scan_found, scan_code and a scan_done strobe;
//     owns the press/release counters; outputs key, key_detected, key_pulse.
//   - Top level: synchronizer, column phase counter, priority encoder.
//
// TESTING (SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, scan = 16 cycles; keypad model pulls
//   row[r] low while col[c] is low and key (r,c) is pressed)
//   1. Assert rst_n=0 then release -> col=1110, key=0, key_detected=0, key_pulse=0;
//      col then cycles 1110,1101,1011,0111 every 4 cycles.
//   2. Hold (r0,c0) -> key=4'd1, key_detected=1 within 3 scans+2 cycles,
//      exactly one key_pulse; release -> key_detected=0 within 3 scans, key stays 1.
//   3. Hold (r3,c1) -> key=4'd15 with one pulse.
//      Hold (r0,c3) after release -> key=4'hA with one new pulse.
//   4. Hold (r1,c1) for 1 scan only, then release -> no key_pulse, key_detected stays 0.
//   5. Hold (r0,c1) and (r1,c1) together -> key=4'd2.
//      While held, drop (r0,c1) -> key stays 2 and no second pulse.
//   6. Hold (r2,c2) until key_detected=1; pulse rst_n low mid-scan -> outputs clear at once.
//      Key still held after release -> key=4'd9 again with a fresh key_pulse.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes, the row/column
// key map, the column-phase index type and the debouncer state encoding.
package keypad_scanner_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef logic [1:0] col_idx_t;

  typedef enum logic {
    DEB_IDLE = 1'b0,
    DEB_HELD = 1'b1
  } deb_state_t;

  // Physical keypad legend, rows top to bottom, columns left to right.
  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input col_idx_t col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_0;
      4'b11_01: code = KEY_F;
      4'b11_10: code = KEY_E;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_debouncer.sv
// Whole-scan debouncer: counts consecutive agreeing scans to accept a press
// or a release, and emits the accepted code plus a one-cycle press pulse.
module key_debouncer
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_done,
  input  logic       scan_found,
  input  logic [3:0] scan_code,
  output logic [3:0] key,
  output logic       key_detected,
  output logic       key_pulse
);

  localparam int              DEB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

  deb_state_t       state_reg, state_next;
  logic [DEB_W-1:0] press_cnt_reg, press_cnt_next;
  logic [DEB_W-1:0] release_cnt_reg, release_cnt_next;
  logic [3:0]       cand_reg, cand_next;
  logic [3:0]       key_reg;
  logic             pulse_reg;
  logic             press_accept, release_accept;

  // Counter updates; both counters saturate at DEB_MAX.
  always_comb begin
    press_cnt_next   = press_cnt_reg;
    release_cnt_next = release_cnt_reg;
    cand_next        = cand_reg;
    press_accept     = 1'b0;
    release_accept   = 1'b0;
    if (scan_done) begin
      if (state_reg == DEB_IDLE) begin
        if (scan_found && scan_code == cand_reg) begin
          press_cnt_next = (press_cnt_reg == DEB_MAX) ? DEB_MAX : press_cnt_reg + DEB_ONE;
        end else if (scan_found) begin
          cand_next      = scan_code;
          press_cnt_next = DEB_ONE;
        end else begin
          press_cnt_next = '0;
        end
        if (press_cnt_next == DEB_MAX) begin
          press_accept     = 1'b1;
          release_cnt_next = '0;
        end
      end else begin
        if (scan_found) begin
          release_cnt_next = '0;
        end else begin
          release_cnt_next = (release_cnt_reg == DEB_MAX) ? DEB_MAX : release_cnt_reg + DEB_ONE;
        end
        if (release_cnt_next == DEB_MAX) begin
          release_accept   = 1'b1;
          press_cnt_next   = '0;
          release_cnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DEB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DEB_IDLE: if (press_accept)   state_next = DEB_HELD;
      DEB_HELD: if (release_accept) state_next = DEB_IDLE;
      default:                      state_next = DEB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_cnt_reg   <= '0;
      release_cnt_reg <= '0;
      cand_reg        <= KEY_0;
      key_reg         <= KEY_0;
      pulse_reg       <= 1'b0;
    end else begin
      press_cnt_reg   <= press_cnt_next;
      release_cnt_reg <= release_cnt_next;
      cand_reg        <= cand_next;
      pulse_reg       <= press_accept;
      if (press_accept) key_reg <= cand_next;
    end
  end

  always_comb begin
    key          = key_reg;
    key_detected = (state_reg == DEB_HELD);
    key_pulse    = pulse_reg;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan driver: walks the columns, samples synchronized rows at the
// end of each column phase, and hands one result per scan to the debouncer.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 100_000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_detected,
  output logic       key_pulse
);

  localparam int              CNT_W       = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [3:0]       row_meta_reg, row_sync_reg;
  logic [CNT_W-1:0] settle_cnt_reg;
  col_idx_t         col_idx_reg;
  logic             found_reg;
  logic [3:0]       code_reg;

  logic             phase_end;
  logic             row_found;
  logic [3:0]       row_code;
  logic             scan_done, scan_found;
  logic [3:0]       scan_code;

  // Idle rows are pulled up, so the synchronizer resets to "no key".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= row;
      row_sync_reg <= row_meta_reg;
    end
  end

  assign phase_end = (settle_cnt_reg == SETTLE_LAST);
  assign scan_done = phase_end && (col_idx_reg == col_idx_t'(3));

  // Lowest-numbered low row in the current column wins.
  always_comb begin
    row_found = 1'b0;
    row_code  = KEY_0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_reg[r]) begin
        row_found = 1'b1;
        row_code  = key_map(2'(r), col_idx_reg);
      end
    end
  end

  // A hit latched in an earlier column of this scan takes precedence.
  assign scan_found = found_reg | (phase_end & row_found);
  assign scan_code  = found_reg ? code_reg : row_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_reg <= '0;
      col_idx_reg    <= '0;
      found_reg      <= 1'b0;
      code_reg       <= KEY_0;
    end else begin
      settle_cnt_reg <= phase_end ? '0 : settle_cnt_reg + CNT_ONE;
      if (phase_end) begin
        col_idx_reg <= col_idx_reg + col_idx_t'(1);
        if (scan_done) begin
          found_reg <= 1'b0;
          code_reg  <= KEY_0;
        end else if (!found_reg && row_found) begin
          found_reg <= 1'b1;
          code_reg  <= row_code;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col[gi] = (col_idx_reg != col_idx_t'(gi));
    end
  endgenerate

  key_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_done   (scan_done),
    .scan_found  (scan_found),
    .scan_code   (scan_code),
    .key         (key),
    .key_detected(key_detected),
    .key_pulse   (key_pulse)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized checks of keypad_scanner against a keypad model and
// a first-key-in-scan-order reference.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 2;
  localparam int SCAN   = 4 * SETTLE;
  localparam int LIMIT  = 3 * SCAN + 4;

  // Legend indexed r*4+c.
  localparam logic [3:0] KEY_TABLE [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                            4'h4, 4'h5, 4'h6, 4'hB,
                                            4'h7, 4'h8, 4'h9, 4'hC,
                                            4'h0, 4'hF, 4'hE, 4'hD};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_detected;
  logic       key_pulse;
  logic [15:0] pressed = '0;

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int pulse_cnt = 0;
  int viol_cnt = 0;
  logic prev_det = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key         (key),
    .key_detected(key_detected),
    .key_pulse   (key_pulse)
  );

  // Passive keypad: a pressed key shorts its row to its column when driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Pulses must coincide exactly with rising edges of key_detected.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_det <= 1'b0;
    end else begin
      if (key_pulse) pulse_cnt <= pulse_cnt + 1;
      if (key_pulse !== (key_detected && !prev_det)) viol_cnt <= viol_cnt + 1;
      prev_det <= key_detected;
    end
  end

  function automatic logic [3:0] expected_code(input logic [15:0] keys);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[r*4+c]) return KEY_TABLE[r*4+c];
    return 4'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_det(input logic level, input string tag);
    int n = 0;
    while (key_detected !== level && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key_detected), 32'(level));
  endtask

  initial begin
    logic [3:0] exp_col;
    logic [3:0] exp_key;
    int p0;

    // 1. Reset state and column walk.
    cycles(3);
    check("rst_col", 32'(col), 32'hE);
    check("rst_key", 32'(key), 32'h0);
    check("rst_det", 32'(key_detected), 32'h0);
    check("rst_pulse", 32'(key_pulse), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * SCAN; k++) begin
      exp_col = 4'b0001 << ((k / SETTLE) % 4);
      exp_col = ~exp_col;
      check($sformatf("col_walk_%0d", k), 32'(col), 32'(exp_col));
      @(negedge clk);
    end

    // 2. Single key (r0,c0).
    p0 = pulse_cnt;
    pressed[0] = 1'b1;
    wait_det(1'b1, "k1_det");
    check("k1_key", 32'(key), 32'h1);
    cycles(3);
    check("k1_pulses", 32'(pulse_cnt), 32'(p0 + 1));
    pressed = '0;
    wait_det(1'b0, "k1_rel");
    check("k1_key_hold", 32'(key), 32'h1);

    // 3. (r3,c1) then (r0,c3).
    p0 = pulse_cnt;
    pressed[13] = 1'b1;
    wait_det(1'b1, "kF_det");
    check("kF_key", 32'(key), 32'hF);
    pressed = '0;
    wait_det(1'b0, "kF_rel");
    pressed[3] = 1'b1;
    wait_det(1'b1, "kA_det");
    check("kA_key", 32'(key), 32'hA);
    cycles(3);
    check("kFA_pulses", 32'(pulse_cnt), 32'(p0 + 2));
    pressed = '0;
    wait_det(1'b0, "kA_rel");

    // 4. One-scan glitch must be rejected.
    p0 = pulse_cnt;
    pressed[5] = 1'b1;
    cycles(SCAN);
    pressed = '0;
    cycles(4 * SCAN);
    check("glitch_det", 32'(key_detected), 32'h0);
    check("glitch_pulses", 32'(pulse_cnt), 32'(p0));
    check("glitch_key", 32'(key), 32'hA);

    // 5. Two keys in the same column; row0 wins, then row0 drops.
    p0 = pulse_cnt;
    pressed[1] = 1'b1;
    pressed[5] = 1'b1;
    wait_det(1'b1, "multi_det");
    check("multi_key", 32'(key), 32'h2);
    pressed[1] = 1'b0;
    cycles(4 * SCAN);
    check("multi_key_after", 32'(key), 32'h2);
    check("multi_det_after", 32'(key_detected), 32'h1);
    check("multi_pulses", 32'(pulse_cnt), 32'(p0 + 1));
    pressed = '0;
    wait_det(1'b0, "multi_rel");

    // 6. Reset mid-press, then re-debounce.
    pressed[10] = 1'b1;
    wait_det(1'b1, "k9_det");
    cycles(5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_col", 32'(col), 32'hE);
    check("mid_rst_key", 32'(key), 32'h0);
    check("mid_rst_det", 32'(key_detected), 32'h0);
    check("mid_rst_pulse", 32'(key_pulse), 32'h0);
    cycles(3);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    wait_det(1'b1, "k9_redet");
    check("k9_key", 32'(key), 32'h9);
    cycles(3);
    check("k9_pulses", 32'(pulse_cnt), 32'(p0 + 1));
    pressed = '0;
    wait_det(1'b0, "k9_rel");

    // Randomized key combinations against the scan-order reference.
    for (int it = 0; it < 10; it++) begin
      int n;
      pressed = '0;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) pressed[$urandom_range(0, 15)] = 1'b1;
      exp_key = expected_code(pressed);
      p0 = pulse_cnt;
      cycles($urandom_range(0, SCAN - 1));
      wait_det(1'b1, $sformatf("rnd%0d_det", it));
      check($sformatf("rnd%0d_key", it), 32'(key), 32'(exp_key));
      cycles(3);
      check($sformatf("rnd%0d_pulses", it), 32'(pulse_cnt), 32'(p0 + 1));
      pressed = '0;
      wait_det(1'b0, $sformatf("rnd%0d_rel", it));
      check($sformatf("rnd%0d_key_hold", it), 32'(key), 32'(exp_key));
    end

    check("pulse_alignment_violations", 32'(viol_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
